// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file bus sequencer.
// Holds the command op encoding, register index names, FSM states, the
// packed command payload carried through the FIFO and the onehot() helper.
package regfile_seq_pkg;

  localparam int unsigned REG_COUNT       = 11;
  localparam int unsigned REG_WIDTH       = 12;
  localparam int unsigned IDX_WIDTH       = 4;
  localparam int unsigned FIFO_DEPTH_DFLT = 4;

  typedef enum logic [1:0] {
    OP_MOVE     = 2'd0,
    OP_LOAD_IMM = 2'd1,
    OP_INC      = 2'd2,
    OP_CLR      = 2'd3
  } op_e;

  // Register file map
  localparam logic [IDX_WIDTH-1:0] REG_R       = 4'd0;
  localparam logic [IDX_WIDTH-1:0] REG_ROW     = 4'd1;
  localparam logic [IDX_WIDTH-1:0] REG_CAT     = 4'd2;
  localparam logic [IDX_WIDTH-1:0] REG_CB      = 4'd3;
  localparam logic [IDX_WIDTH-1:0] REG_RNOW    = 4'd4;
  localparam logic [IDX_WIDTH-1:0] REG_CATNOW  = 4'd5;
  localparam logic [IDX_WIDTH-1:0] REG_CBNOW   = 4'd6;
  localparam logic [IDX_WIDTH-1:0] REG_ALPHAP  = 4'd7;
  localparam logic [IDX_WIDTH-1:0] REG_BETAP   = 4'd8;
  localparam logic [IDX_WIDTH-1:0] REG_GAMMAP  = 4'd9;
  localparam logic [IDX_WIDTH-1:0] REG_TOTAL   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [IDX_WIDTH-1:0] src;
    logic [IDX_WIDTH-1:0] dst;
    logic [REG_WIDTH-1:0] imm;
  } cmd_t;

  localparam int unsigned CMD_WIDTH = $bits(cmd_t);

  // Register index to strobe vector; caller guarantees idx < REG_COUNT.
  function automatic logic [REG_COUNT-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
    return REG_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers.
// Ports: clk, reset (sync, active-high), push_i/data_i write side,
// pop_i read side, head_o (current head entry), full_o, empty_o,
// count_o (entries held). Push when full and pop when empty are ignored.
module regfile_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/regfile_bus_sequencer.sv
// Command-driven bus master for the 11-entry core register file.
// Commands (MOVE, LOAD_IMM, INC, CLR) arrive over cmd_valid/cmd_ready, are
// queued in regfile_cmd_fifo and turned into one-hot read/write strobes.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_src/
// cmd_dst/cmd_imm command side; rf_data from the register file dataout;
// read_en/write_en/bus_out to the register file; done, err, busy status.
// All outputs registered.
// Build option: define REGFILE_SEQ_INC_EN to support INC; otherwise INC is
// treated as an illegal command.
module regfile_bus_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [IDX_WIDTH-1:0] cmd_src,
  input  logic [IDX_WIDTH-1:0] cmd_dst,
  input  logic [REG_WIDTH-1:0] cmd_imm,
  input  logic [REG_WIDTH-1:0] rf_data,
  output logic [REG_COUNT-1:0] read_en,
  output logic [REG_COUNT-1:0] write_en,
  output logic [REG_WIDTH-1:0] bus_out,
  output logic                 done,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cur_dst_q, cur_dst_d;
  logic [REG_COUNT-1:0]  read_en_q, read_en_d;
  logic [REG_COUNT-1:0]  write_en_q, write_en_d;
  logic [REG_WIDTH-1:0]  bus_out_q, bus_out_d;  // doubles as the hold register
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  cmd_ready_q, cmd_ready_d;
`ifdef REGFILE_SEQ_INC_EN
  logic                  cur_inc_q, cur_inc_d;
`endif

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_next;
  logic [CMD_WIDTH-1:0]  fifo_head;
  cmd_t                  head;
  logic                  src_ok;
  logic                  dst_ok;
  logic                  head_legal;

  assign fifo_push = cmd_valid && !fifo_full;
  assign head      = cmd_t'(fifo_head);

  regfile_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  ({cmd_op, cmd_src, cmd_dst, cmd_imm}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Legality of the FIFO head: only fields the op uses are range-checked
  always_comb begin
    head_legal = 1'b0;
    src_ok     = (head.src < IDX_WIDTH'(REG_COUNT));
    dst_ok     = (head.dst < IDX_WIDTH'(REG_COUNT));
    case (head.op)
      OP_MOVE: head_legal = src_ok && dst_ok;
`ifdef REGFILE_SEQ_INC_EN
      OP_INC:  head_legal = src_ok && dst_ok;
`else
      OP_INC:  head_legal = 1'b0;
`endif
      default: head_legal = dst_ok;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cur_dst_d  = cur_dst_q;
    read_en_d  = '0;
    write_en_d = '0;
    bus_out_d  = bus_out_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fifo_pop   = 1'b0;
`ifdef REGFILE_SEQ_INC_EN
    cur_inc_d  = cur_inc_q;
`endif

    case (state_q)
      ST_READ: begin
        // rf_data reflects the register selected during this READ cycle
`ifdef REGFILE_SEQ_INC_EN
        bus_out_d = cur_inc_q ? (rf_data + REG_WIDTH'(1)) : rf_data;
`else
        bus_out_d = rf_data;
`endif
        write_en_d = onehot(cur_dst_q);
        done_d     = 1'b1;
        state_d    = ST_WRITE;
      end
      default: begin
        // IDLE and WRITE both issue the next command without a bubble
        state_d = ST_IDLE;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!head_legal) begin
            err_d = 1'b1;
          end else begin
            case (head.op)
              OP_MOVE, OP_INC: begin
                read_en_d = onehot(head.src);
                cur_dst_d = head.dst;
`ifdef REGFILE_SEQ_INC_EN
                cur_inc_d = (head.op == OP_INC);
`endif
                state_d   = ST_READ;
              end
              OP_LOAD_IMM: begin
                write_en_d = onehot(head.dst);
                bus_out_d  = head.imm;
                done_d     = 1'b1;
                state_d    = ST_WRITE;
              end
              default: begin
                write_en_d = onehot(head.dst);
                bus_out_d  = '0;
                done_d     = 1'b1;
                state_d    = ST_WRITE;
              end
            endcase
          end
        end
      end
    endcase

    count_next  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    busy_d      = (state_d != ST_IDLE) || (count_next != '0);
    cmd_ready_d = (count_next != CW'(FIFO_DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_dst_q   <= '0;
      read_en_q   <= '0;
      write_en_q  <= '0;
      bus_out_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
`ifdef REGFILE_SEQ_INC_EN
      cur_inc_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_dst_q   <= cur_dst_d;
      read_en_q   <= read_en_d;
      write_en_q  <= write_en_d;
      bus_out_q   <= bus_out_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef REGFILE_SEQ_INC_EN
      cur_inc_q   <= cur_inc_d;
`endif
    end
  end

  assign read_en   = read_en_q;
  assign write_en  = write_en_q;
  assign bus_out   = bus_out_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_regfile_bus_sequencer.sv
// Self-checking bench for regfile_bus_sequencer: a register-file model
// answers read strobes, and a queue-based transaction model predicts every
// output each cycle from the command rules.
module tb_regfile_bus_sequencer;
  import regfile_seq_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    int op;
    int src;
    int dst;
    int imm;
  } tcmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_src;
  logic [3:0]  cmd_dst;
  logic [11:0] cmd_imm;
  logic [11:0] rf_data;
  logic [10:0] read_en;
  logic [10:0] write_en;
  logic [11:0] bus_out;
  logic        done;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  regfile_bus_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_imm   (cmd_imm),
    .rf_data   (rf_data),
    .read_en   (read_en),
    .write_en  (write_en),
    .bus_out   (bus_out),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  // Register file driven by the DUT strobes
  logic [11:0] rf [11];
  always @(posedge clk) begin
    for (int i = 0; i < 11; i++) if (write_en[i]) rf[i] <= bus_out;
  end
  always_comb begin
    rf_data = 12'hA5A;
    for (int i = 0; i < 11; i++) if (read_en[i]) rf_data = rf[i];
  end

  // Transaction model state
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  tcmd_t       m_q[$];
  logic        m_pend = 1'b0;
  tcmd_t       m_pcmd;
  logic        m_wr = 1'b0;
  int          m_wr_idx;
  int          m_wr_val;
  int          regs[11];
  logic [10:0] e_rd, e_wr;
  logic [11:0] e_bus = 12'h000;
  logic        e_done, e_err, e_busy, e_ready;
  logic        saw_full;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input tcmd_t c);
    bit inc_en;
`ifdef REGFILE_SEQ_INC_EN
    inc_en = 1'b1;
`else
    inc_en = 1'b0;
`endif
    if (c.dst >= 11) return 1'b1;
    if ((c.op == 0 || c.op == 2) && c.src >= 11) return 1'b1;
    if (c.op == 2 && !inc_en) return 1'b1;
    return 1'b0;
  endfunction

  // Predict the outputs after the coming clock edge
  task automatic model_step(input logic rst, input logic vld, input tcmd_t c);
    bit    do_push;
    tcmd_t h;
    int    v;
    if (m_wr) regs[m_wr_idx] = m_wr_val;
    m_wr   = 1'b0;
    e_rd   = '0;
    e_wr   = '0;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (rst) begin
      m_q.delete();
      m_pend  = 1'b0;
      e_bus   = '0;
      e_busy  = 1'b0;
      e_ready = 1'b1;
      return;
    end
    do_push = vld && (m_q.size() < DEPTH);
    if (m_pend) begin
      v = regs[m_pcmd.src];
      if (m_pcmd.op == 2) v = (v + 1) % 4096;
      e_wr = 11'(1) << m_pcmd.dst; e_bus = 12'(v); e_done = 1'b1;
      m_wr = 1'b1; m_wr_idx = m_pcmd.dst; m_wr_val = v;
      m_pend = 1'b0;
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
      if (is_illegal(h)) begin
        e_err = 1'b1;
      end else if (h.op == 0 || h.op == 2) begin
        e_rd   = 11'(1) << h.src;
        m_pend = 1'b1;
        m_pcmd = h;
      end else begin
        v = (h.op == 1) ? h.imm : 0;
        e_wr = 11'(1) << h.dst; e_bus = 12'(v); e_done = 1'b1;
        m_wr = 1'b1; m_wr_idx = h.dst; m_wr_val = v;
      end
    end
    if (do_push) m_q.push_back(c);
    e_busy  = m_pend || (e_wr != '0) || (m_q.size() > 0);
    e_ready = (m_q.size() < DEPTH);
  endtask

  task automatic cycle(input logic rst, input logic vld, input tcmd_t c);
    reset     = rst;
    cmd_valid = vld;
    cmd_op    = 2'(c.op);
    cmd_src   = 4'(c.src);
    cmd_dst   = 4'(c.dst);
    cmd_imm   = 12'(c.imm);
    model_step(rst, vld, c);
    @(posedge clk);
    #1;
    check_eq("read_en", read_en, e_rd);
    check_eq("write_en", write_en, e_wr);
    check_eq("bus_out", bus_out, e_bus);
    check_eq("done", done, e_done);
    check_eq("err", err, e_err);
    check_eq("busy", busy, e_busy);
    check_eq("cmd_ready", cmd_ready, e_ready);
    if (!cmd_ready) saw_full = 1'b1;
  endtask

  function automatic tcmd_t mk(input int op, input int src, input int dst, input int imm);
    tcmd_t c;
    c.op = op; c.src = src; c.dst = dst; c.imm = imm;
    return c;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
  endtask

  initial begin
    tcmd_t c;
    int    sent;
    int    guard;
    saw_full = 1'b0;
    for (int i = 0; i < 11; i++) regs[i] = 0;

    // Reset state
    cycle(1'b1, 1'b0, mk(0, 0, 0, 0));
    cycle(1'b1, 1'b0, mk(0, 0, 0, 0));
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bus", bus_out, 0);
    idle(1);

    // Preload every register so reads return known data
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1, mk(1, 0, i, int'($urandom_range(0, 4095))));
    idle(3);

    // LOAD_IMM alphap <- 0x11A
    cycle(1'b0, 1'b1, mk(1, 0, 7, 'h11A));
    cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
    check_eq("li_wen", write_en, 11'h080);
    check_eq("li_bus", bus_out, 12'h11A);
    check_eq("li_done", done, 1);
    cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
    check_eq("li_done_once", done, 0);

    // MOVE alphap -> rnow
    cycle(1'b0, 1'b1, mk(0, 7, 4, 0));
    cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
    check_eq("mv_ren", read_en, 11'h080);
    cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
    check_eq("mv_wen", write_en, 11'h010);
    check_eq("mv_bus", bus_out, 12'h11A);
    idle(1);

    // INC Total with 0xFFF stored wraps to 0
    cycle(1'b0, 1'b1, mk(1, 0, 10, 'hFFF));
    idle(2);
    cycle(1'b0, 1'b1, mk(2, 10, 10, 0));
    cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
`ifdef REGFILE_SEQ_INC_EN
    check_eq("inc_ren", read_en, 11'h400);
    cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
    check_eq("inc_wen", write_en, 11'h400);
    check_eq("inc_wrap", bus_out, 12'h000);
`else
    check_eq("inc_err", err, 1);
    check_eq("inc_ren", read_en, 0);
    cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
    check_eq("inc_wen", write_en, 0);
`endif
    idle(2);

    // Illegal MOVE src=11 followed by a legal LOAD_IMM
    cycle(1'b0, 1'b1, mk(0, 11, 0, 0));
    cycle(1'b0, 1'b1, mk(1, 0, 0, 'h5A5));
    check_eq("ill_err", err, 1);
    check_eq("ill_ren", read_en, 0);
    cycle(1'b0, 1'b0, mk(0, 0, 0, 0));
    check_eq("ill_err_once", err, 0);
    check_eq("after_ill_wen", write_en, 11'h001);
    check_eq("after_ill_bus", bus_out, 12'h5A5);
    idle(2);

    // Flood with MOVEs, valid held until accepted: FIFO must fill
    saw_full = 1'b0;
    sent  = 0;
    guard = 0;
    c = mk(0, int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 0);
    while (sent < 10 && guard < 100) begin
      if (e_ready) begin
        cycle(1'b0, 1'b1, c);
        sent++;
        c = mk(0, int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 0);
      end else begin
        cycle(1'b0, 1'b1, c);
      end
      guard++;
    end
    check_eq("flood_sent", sent, 10);
    check_eq("full_seen", saw_full, 1);
    idle(25);

    // Reset during a MOVE's READ cycle abandons it and the queue
    cycle(1'b0, 1'b1, mk(0, 1, 2, 0));
    cycle(1'b0, 1'b1, mk(1, 0, 3, 'h123));
    check_eq("rr_ren", read_en, 11'h002);
    cycle(1'b1, 1'b1, mk(1, 0, 4, 'h456));
    check_eq("rr_ren0", read_en, 0);
    check_eq("rr_wen0", write_en, 0);
    check_eq("rr_busy0", busy, 0);
    idle(5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      c = mk(int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10)),
             int'($urandom_range(0, 4095)));
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) < 7), c);
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
